// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types, tables and defaults for the RTC transaction scheduler
package rtc_pkg;

   // Scheduler states
   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT_FIN,
      ST_GAP
   } state_e;

   // Kind of the transaction currently owning control_salida
   typedef enum logic [1:0] {
      K_INIT,
      K_READ,
      K_USER
   } kind_e;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } init_entry_t;

   localparam int DEF_REFRESH_CYCLES = 1_000_000;
   localparam int DEF_NUM_REGS       = 6;
   localparam int DEF_TIMEOUT        = 255;

   // Shadow bank size: seg, min, hora, dia, mes, anio
   localparam int MAX_REGS = 6;
   localparam int BW       = $clog2(MAX_REGS);

   // Time/date register addresses, entry 0 is the rightmost
   localparam logic [MAX_REGS-1:0][7:0] REG_ADDR =
      {8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21};

   // One-time init writes issued after reset, entry 0 first: 0x02<=0x10 then 0x02<=0x00
   localparam int INIT_COUNT = 2;
   localparam int INIT_IW    = (INIT_COUNT > 1) ? $clog2(INIT_COUNT) : 1;
   localparam init_entry_t [INIT_COUNT-1:0] INIT_TABLE = {16'h0200, 16'h0210};

endpackage

// File: rtl/rtc_temporizador.sv
// rtl/rtc_temporizador.sv - free-running refresh counter with coalescing pending flag
module rtc_temporizador
   import rtc_pkg::*;
#(
   parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
   input  logic clk_i,
   input  logic reset_ni,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   logic [CW-1:0] cnt_q;
   logic          pend_q;
   logic          wrap;

   assign wrap   = (cnt_q == CW'(REFRESH_CYCLES - 1));
   assign tick_o = pend_q;

   // Counter wraps at REFRESH_CYCLES-1; a wrap always wins over a clear so no period is lost
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         cnt_q <= wrap ? '0 : cnt_q + 1'b1;
         if (wrap) begin
            pend_q <= 1'b1;
         end else if (clear_i) begin
            pend_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/rtc_planificador.sv
// rtl/rtc_planificador.sv - sole master of control_salida: init writes, refresh bursts, user writes
module rtc_planificador
   import rtc_pkg::*;
#(
   parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
   parameter int NUM_REGS       = DEF_NUM_REGS,
   parameter int TIMEOUT        = DEF_TIMEOUT
) (
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       final_i,
   input  logic [7:0] dato_rd_i,
   input  logic       wr_req_i,
   input  logic [7:0] wr_dir_i,
   input  logic [7:0] wr_dato_i,
   output logic       wr_ack_o,
   output logic       iniciar_o,
   output logic       escribe_o,
   output logic [7:0] direccion_o,
   output logic [7:0] dato_o,
   output logic [7:0] seg_o,
   output logic [7:0] min_o,
   output logic [7:0] hora_o,
   output logic [7:0] dia_o,
   output logic [7:0] mes_o,
   output logic [7:0] anio_o,
   output logic       actualizado_o,
   output logic       ocupado_o,
   output logic       error_o
);

   localparam int TO_W = $clog2(TIMEOUT + 1);

   state_e               state_q, state_d;
   kind_e                kind_q, kind_d;
   logic                 final_q;
   logic [TO_W-1:0]      to_cnt_q;
   logic [INIT_IW-1:0]   init_idx_q, init_idx_d;
   logic [BW-1:0]        burst_idx_q, burst_idx_d;
   logic                 more_q, more_d;
   logic                 escribe_q, escribe_d;
   logic [7:0]           dir_q, dir_d;
   logic [7:0]           dato_q, dato_d;
   logic [7:0]           rd_buf_q [MAX_REGS];
   logic [7:0]           sh_q [MAX_REGS];
   logic                 act_q, ack_q, block_q, error_q, ocupado_q;

   logic                 pend, clr_pend;
   logic                 rise, in_flight, to_hit;
   logic                 ld_txn, ld_shadow, user_done, arb;

   rtc_temporizador #(
      .REFRESH_CYCLES(REFRESH_CYCLES)
   ) u_temporizador (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .clear_i  (clr_pend),
      .tick_o   (pend)
   );

   // Only the rising edge of final matters; a level already high at launch is ignored
   assign rise      = final_i & ~final_q;
   assign in_flight = (state_q == ST_LAUNCH) || (state_q == ST_WAIT_FIN);
   assign to_hit    = (to_cnt_q == TO_W'(TIMEOUT - 1));

   // Next-state: sequencing of init/burst entries and arbitration (user write before refresh)
   always_comb begin
      state_d     = state_q;
      kind_d      = kind_q;
      init_idx_d  = init_idx_q;
      burst_idx_d = burst_idx_q;
      more_d      = more_q;
      escribe_d   = escribe_q;
      dir_d       = dir_q;
      dato_d      = dato_q;
      ld_txn      = 1'b0;
      clr_pend    = 1'b0;
      ld_shadow   = 1'b0;
      user_done   = 1'b0;
      arb         = 1'b0;

      case (state_q)
         ST_INIT: begin
            ld_txn     = 1'b1;
            kind_d     = K_INIT;
            init_idx_d = '0;
            escribe_d  = 1'b1;
            dir_d      = INIT_TABLE[0].addr;
            dato_d     = INIT_TABLE[0].data;
            state_d    = ST_LAUNCH;
         end
         ST_IDLE: arb = 1'b1;
         ST_LAUNCH, ST_WAIT_FIN: begin
            if (rise || to_hit) begin
               state_d = ST_GAP;
               case (kind_q)
                  K_INIT: more_d = (init_idx_q != INIT_IW'(INIT_COUNT - 1));
                  K_READ: begin
                     // A timed-out read abandons the rest of the burst so the snapshot stays coherent
                     more_d    = rise && (burst_idx_q != BW'(NUM_REGS - 1));
                     ld_shadow = rise && (burst_idx_q == BW'(NUM_REGS - 1));
                  end
                  default: begin
                     more_d    = 1'b0;
                     user_done = 1'b1;
                  end
               endcase
            end else begin
               state_d = ST_WAIT_FIN;
            end
         end
         ST_GAP: begin
            if (more_q) begin
               ld_txn  = 1'b1;
               state_d = ST_LAUNCH;
               if (kind_q == K_INIT) begin
                  init_idx_d = init_idx_q + 1'b1;
                  escribe_d  = 1'b1;
                  dir_d      = INIT_TABLE[init_idx_d].addr;
                  dato_d     = INIT_TABLE[init_idx_d].data;
               end else begin
                  burst_idx_d = burst_idx_q + 1'b1;
                  escribe_d   = 1'b0;
                  dir_d       = REG_ADDR[burst_idx_d];
                  dato_d      = '0;
               end
            end else begin
               arb = 1'b1;
            end
         end
         default: state_d = ST_INIT;
      endcase

      if (arb) begin
         if (wr_req_i && !block_q) begin
            ld_txn    = 1'b1;
            kind_d    = K_USER;
            escribe_d = 1'b1;
            dir_d     = wr_dir_i;
            dato_d    = wr_dato_i;
            state_d   = ST_LAUNCH;
         end else if (pend) begin
            ld_txn      = 1'b1;
            kind_d      = K_READ;
            clr_pend    = 1'b1;
            burst_idx_d = '0;
            escribe_d   = 1'b0;
            dir_d       = REG_ADDR[0];
            dato_d      = '0;
            state_d     = ST_LAUNCH;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   // FSM state, transaction fields, timeout counter and status flags
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= ST_INIT;
         kind_q      <= K_INIT;
         final_q     <= 1'b0;
         to_cnt_q    <= '0;
         init_idx_q  <= '0;
         burst_idx_q <= '0;
         more_q      <= 1'b0;
         escribe_q   <= 1'b0;
         dir_q       <= '0;
         dato_q      <= '0;
         act_q       <= 1'b0;
         ack_q       <= 1'b0;
         block_q     <= 1'b0;
         error_q     <= 1'b0;
         ocupado_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         kind_q      <= kind_d;
         final_q     <= final_i;
         init_idx_q  <= init_idx_d;
         burst_idx_q <= burst_idx_d;
         more_q      <= more_d;
         escribe_q   <= escribe_d;
         dir_q       <= dir_d;
         dato_q      <= dato_d;
         act_q       <= ld_shadow;
         ack_q       <= user_done;
         ocupado_q   <= (state_d != ST_IDLE);
         if (ld_txn) begin
            to_cnt_q <= '0;
         end else if (in_flight) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
         if (in_flight && !rise && to_hit) begin
            error_q <= 1'b1;
         end
         // A held request is not re-served until the requester drops it
         if (user_done) begin
            block_q <= 1'b1;
         end else if (!wr_req_i) begin
            block_q <= 1'b0;
         end
      end
   end

   // Burst buffer captures each read; shadows load together when the last read lands
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         for (int i = 0; i < MAX_REGS; i++) begin
            rd_buf_q[i] <= '0;
            sh_q[i]     <= '0;
         end
      end else begin
         if (in_flight && rise && (kind_q == K_READ)) begin
            rd_buf_q[burst_idx_q] <= dato_rd_i;
         end
         if (ld_shadow) begin
            for (int i = 0; i < MAX_REGS; i++) begin
               if (i < NUM_REGS) begin
                  sh_q[i] <= (BW'(i) == burst_idx_q) ? dato_rd_i : rd_buf_q[i];
               end
            end
         end
      end
   end

   assign iniciar_o     = in_flight;
   assign escribe_o     = escribe_q;
   assign direccion_o   = dir_q;
   assign dato_o        = dato_q;
   assign wr_ack_o      = ack_q;
   assign actualizado_o = act_q;
   assign ocupado_o     = ocupado_q;
   assign error_o       = error_q;
   assign seg_o         = sh_q[0];
   assign min_o         = sh_q[1];
   assign hora_o        = sh_q[2];
   assign dia_o         = sh_q[3];
   assign mes_o         = sh_q[4];
   assign anio_o        = sh_q[5];

endmodule

// File: tb/tb_rtc_planificador.sv
// tb/tb_rtc_planificador.sv - directed self-checking bench with behavioural control_salida model
module tb_rtc_planificador;

   localparam int N = 5;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       fin = 1'b0;
   logic       wr_req = 1'b0;
   logic [7:0] wr_dir = 8'h00;
   logic [7:0] wr_dato = 8'h00;
   logic [7:0] dato_rd;
   logic       wr_ack, iniciar, escribe, actualizado, ocupado, error;
   logic [7:0] direccion, dato, seg, min, hora, dia, mes, anio;

   logic [7:0] mem [0:255];
   int         checks = 0;
   int         errors = 0;
   int         cyc;
   int         mcnt = 0;
   logic       mute = 1'b0;

   logic [32:0] lq[$];
   logic        ini_prev = 1'b0;
   logic        held_esc = 1'b0;
   logic [7:0]  held_dir = 8'h00;
   logic [7:0]  held_dat = 8'h00;
   int          stab_err = 0;
   int          act_cnt = 0;
   int          ack_cnt = 0;

   always #5 clk = ~clk;

   rtc_planificador #(
      .REFRESH_CYCLES(200),
      .NUM_REGS(6),
      .TIMEOUT(255)
   ) dut (
      .clk_i         (clk),
      .reset_ni      (rst_n),
      .final_i       (fin),
      .dato_rd_i     (dato_rd),
      .wr_req_i      (wr_req),
      .wr_dir_i      (wr_dir),
      .wr_dato_i     (wr_dato),
      .wr_ack_o      (wr_ack),
      .iniciar_o     (iniciar),
      .escribe_o     (escribe),
      .direccion_o   (direccion),
      .dato_o        (dato),
      .seg_o         (seg),
      .min_o         (min),
      .hora_o        (hora),
      .dia_o         (dia),
      .mes_o         (mes),
      .anio_o        (anio),
      .actualizado_o (actualizado),
      .ocupado_o     (ocupado),
      .error_o       (error)
   );

   assign dato_rd = mem[direccion];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // control_salida model: final rises N cycles after iniciar, falls once iniciar drops
   always @(posedge clk) begin
      if (!iniciar) begin
         fin  <= 1'b0;
         mcnt <= 0;
      end else if (!fin && !mute) begin
         if (mcnt == N - 1) fin <= 1'b1;
         mcnt <= mcnt + 1;
      end
   end

   // Records every launch and checks request fields stay stable while iniciar is high
   always @(negedge clk) begin
      if (iniciar && !ini_prev) begin
         lq.push_back({cyc[15:0], escribe, direccion, dato});
         held_esc <= escribe;
         held_dir <= direccion;
         held_dat <= dato;
      end else if (iniciar && ((escribe !== held_esc) || (direccion !== held_dir) || (dato !== held_dat))) begin
         stab_err <= stab_err + 1;
      end
      if (actualizado) act_cnt <= act_cnt + 1;
      if (wr_ack)      ack_cnt <= ack_cnt + 1;
      ini_prev <= iniciar;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_launch(input int idx, input int c, input logic e, input logic [7:0] d, input logic [7:0] v);
      string tag;
      tag = $sformatf("launch%0d", idx);
      if (lq.size() > idx) chk(tag, 64'(lq[idx]), {31'd0, c[15:0], e, d, v});
      else                 chk({tag, "_missing"}, 64'(lq.size()), 64'(idx + 1));
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   function automatic logic [47:0] shadows();
      return {seg, min, hora, dia, mes, anio};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h21] = 8'h59; mem[8'h22] = 8'h30; mem[8'h23] = 8'h12;
      mem[8'h24] = 8'h31; mem[8'h25] = 8'h12; mem[8'h26] = 8'h16;

      repeat (3) @(negedge clk);
      chk("rst_iniciar", 64'(iniciar), 64'd0);
      chk("rst_ocupado", 64'(ocupado), 64'd0);
      chk("rst_error", 64'(error), 64'd0);
      chk("rst_pulses", 64'({wr_ack, actualizado}), 64'd0);
      chk("rst_bus", 64'({escribe, direccion, dato}), 64'd0);
      chk("rst_shadows", 64'(shadows()), 64'd0);
      rst_n = 1'b1;

      // Init sequence
      wait_cyc(7);
      chk("init_gap_iniciar", 64'(iniciar), 64'd0);
      chk("init_gap_ocupado", 64'(ocupado), 64'd1);
      wait_cyc(15);
      chk("init_done_ocupado", 64'(ocupado), 64'd0);
      wait_cyc(16);
      chk_launch(0, 1, 1'b1, 8'h02, 8'h10);
      chk_launch(1, 8, 1'b1, 8'h02, 8'h00);

      // First refresh burst
      wait_cyc(199);
      chk("pre_refresh_launches", 64'(lq.size()), 64'd2);
      chk("pre_refresh_act", 64'(act_cnt), 64'd0);
      wait_cyc(241);
      chk("last_read_shadows_old", 64'(shadows()), 64'd0);
      chk("last_read_act", 64'(actualizado), 64'd0);
      wait_cyc(242);
      chk("burst1_shadows", 64'(shadows()), 64'h593012311216);
      chk("burst1_act", 64'(actualizado), 64'd1);
      wait_cyc(300);
      for (int k = 0; k < 6; k++) chk_launch(2 + k, 201 + 7 * k, 1'b0, 8'h21 + 8'(k), 8'h00);
      chk("burst1_act_count", 64'(act_cnt), 64'd1);

      // User write arriving mid-burst waits for the burst to end
      mem[8'h21] = 8'h05;
      wait_cyc(410);
      wr_dir = 8'h22; wr_dato = 8'h45; wr_req = 1'b1;
      wait_cyc(442);
      chk("burst2_shadows", 64'(shadows()), 64'h053012311216);
      chk("midburst_no_launch", 64'(lq.size()), 64'd14);
      chk_launch(13, 436, 1'b0, 8'h26, 8'h00);
      wait_cyc(449);
      chk("user_wr_ack", 64'(wr_ack), 64'd1);
      wr_req = 1'b0;
      chk_launch(14, 443, 1'b1, 8'h22, 8'h45);
      wait_cyc(460);
      chk("user_ack_count", 64'(ack_cnt), 64'd1);

      // Write request and refresh wrap seen on the same cycle
      mem[8'h22] = 8'h44;
      wait_cyc(600);
      wr_dir = 8'h21; wr_dato = 8'h07; wr_req = 1'b1;
      wait_cyc(607);
      chk("sim_wr_ack", 64'(wr_ack), 64'd1);
      wr_req = 1'b0;
      wait_cyc(649);
      chk_launch(15, 601, 1'b1, 8'h21, 8'h07);
      chk_launch(16, 608, 1'b0, 8'h21, 8'h00);
      chk("burst3_shadows", 64'(shadows()), 64'h054412311216);

      // Timeout: model never answers
      wait_cyc(700);
      mute = 1'b1;
      wait_cyc(1055);
      chk("to_iniciar_held", 64'(iniciar), 64'd1);
      chk("to_error_before", 64'(error), 64'd0);
      wait_cyc(1056);
      chk("to_iniciar_drop", 64'(iniciar), 64'd0);
      chk("to_error_set", 64'(error), 64'd1);
      mute = 1'b0;
      chk_launch(22, 801, 1'b0, 8'h21, 8'h00);
      chk("to_shadows_kept", 64'(shadows()), 64'h054412311216);
      chk("to_act_count", 64'(act_cnt), 64'd3);
      mem[8'h26] = 8'h17;
      wait_cyc(1098);
      chk_launch(23, 1057, 1'b0, 8'h21, 8'h00);
      chk("retry_shadows", 64'(shadows()), 64'h054412311217);
      chk("retry_act", 64'(actualizado), 64'd1);
      chk("error_sticky", 64'(error), 64'd1);
      chk("bus_stability", 64'(stab_err), 64'd0);

      // Reset in the middle of a read
      wait_cyc(1203);
      chk_launch(29, 1201, 1'b0, 8'h21, 8'h00);
      rst_n = 1'b0;
      #1;
      chk("midrst_iniciar", 64'(iniciar), 64'd0);
      chk("midrst_shadows", 64'(shadows()), 64'd0);
      chk("midrst_error", 64'(error), 64'd0);
      chk("midrst_ocupado", 64'(ocupado), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(16);
      chk_launch(30, 1, 1'b1, 8'h02, 8'h10);
      chk_launch(31, 8, 1'b1, 8'h02, 8'h00);
      chk("reinit_idle", 64'(ocupado), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
